// File: rtl/lockstep_pkg.sv
// Shared types and default sizes for the lockstep scheduler.
package lockstep_pkg;

  // Sequencer states; the encoding is fixed so the state can be read on a bus.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 32;
  localparam int LIMW_DEF  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping through the request vector. This returns a one-hot grant, its
// index, and a flag saying whether any request was present.
module rr_arbiter
  import lockstep_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  // Scan from ptr upward and keep only the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a value unassigned and no latch is inferred.
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lockstep_sched.sv
// lockstep_sched: sequencer that shares one counting engine among NREQ
// requesters. A granted job counts from 0 up to that requester's limit.
// The final count is then reported with a one-cycle done pulse. Arbitration
// is round-robin, and only one job is in flight at a time. If the owner drops
// its request while the job runs, the job is abandoned with an aborted pulse.
//
// Optional build macro LOCKSTEP_SCHED_STATS_EN adds two 16-bit wrapping
// counters, jobs_done and jobs_aborted.
module lockstep_sched
  import lockstep_pkg::*;
#(
  parameter int  NREQ  = NREQ_DEF,
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  LIMW  = LIMW_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LIMW-1:0] req_limit,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic [WIDTH-1:0]     result,
`ifdef LOCKSTEP_SCHED_STATS_EN
  output logic [15:0]          jobs_done,
  output logic [15:0]          jobs_aborted,
`endif
  output logic                 aborted
);

  state_t           state, state_nxt;
  logic [NREQ-1:0]  grant_nxt;
  logic [IDW-1:0]   id, id_nxt;
  logic [IDW-1:0]   id_inc;
  logic [LIMW-1:0]  lim, lim_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic [IDW-1:0]   done_id_nxt;
  logic             aborted_nxt;
  logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;

  logic [NREQ-1:0]  arb_onehot;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // The search after this job starts one past its owner, wrapping at NREQ.
  assign id_inc = (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);

  // done is a state decode: high exactly for the single DONE cycle.
  assign done = (state == DONE);
  assign busy = (state == RUN) || (state == DONE);

  // Next-state and datapath decisions; hold everything unless a case changes it.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    id_nxt      = id;
    lim_nxt     = lim;
    count_nxt   = count;
    result_nxt  = result;
    done_id_nxt = done_id;
    aborted_nxt = 1'b0;
    rr_ptr_nxt  = rr_ptr;

    unique case (state)
      IDLE: begin
        if (arb_any) begin
          id_nxt    = arb_idx;
          lim_nxt   = req_limit[arb_idx*LIMW +: LIMW];
          count_nxt = '0;
          grant_nxt = arb_onehot;
          state_nxt = RUN;
        end
      end

      RUN: begin
        // Losing the request wins over reaching the limit in the same cycle.
        if (!req[id]) begin
          aborted_nxt = 1'b1;
          grant_nxt   = '0;
          rr_ptr_nxt  = id_inc;
          state_nxt   = IDLE;
        end else if (count >= WIDTH'(lim)) begin
          result_nxt  = count;
          done_id_nxt = id;
          state_nxt   = DONE;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end

      DONE: begin
        grant_nxt  = '0;
        rr_ptr_nxt = id_inc;
        state_nxt  = IDLE;
      end

      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Datapath and output registers. All of them reset, so a job interrupted by reset leaves no trace.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant   <= '0;
      id      <= '0;
      lim     <= '0;
      count   <= '0;
      result  <= '0;
      done_id <= '0;
      aborted <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      grant   <= grant_nxt;
      id      <= id_nxt;
      lim     <= lim_nxt;
      count   <= count_nxt;
      result  <= result_nxt;
      done_id <= done_id_nxt;
      aborted <= aborted_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

`ifdef LOCKSTEP_SCHED_STATS_EN
  // Completion and abort tallies, both wrapping naturally at 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      jobs_done    <= '0;
      jobs_aborted <= '0;
    end else begin
      if (done)    jobs_done    <= jobs_done + 16'd1;
      if (aborted) jobs_aborted <= jobs_aborted + 16'd1;
    end
  end
`endif

endmodule
